serial_word_capture: RTL and testbench

- Downstream consumer of the team's single-bit D flip-flop storage stage.
- Takes a qualified serial bit stream, one bit per enabled clock, and assembles it into WIDTH-bit words in a shift register.
- Hands each completed word to a holding register with a valid/ready handshake.
- Sits between the bit-level flip-flop chain and the word-level readout logic; flags dropped words as overrun.

---
 rtl/serial_word_capture.sv | 178 +++++++++++++++++
 tb/tb_serial_word_capture.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/serial_word_capture.sv
// ---------------------------------------------------------------------------
// serial_word_capture
//
// Assembles a qualified serial bit stream, one bit per enabled clock, into
// WIDTH-bit words. Each completed word moves into a holding register that is
// read through a valid/ready handshake. A word that completes while the
// holding register still contains an unconsumed word is dropped, and the
// sticky overrun flag is set.
//
// Parameters
//   WIDTH      bits per word (2..32)
//   MSB_FIRST  1: the first received bit lands in word_data[WIDTH-1]
//              0: the first received bit lands in word_data[0]
//
// Optional feature (macro CAPTURE_PARITY_EN)
//   When defined, a frame is WIDTH data bits followed by one even-parity bit.
//   The word completes on the parity bit. The added output parity_err is
//   loaded together with word_data. It holds the XOR of all WIDTH+1 bits of
//   the frame, so 1 means the parity check failed. When not defined, frames
//   are WIDTH bits and parity_err does not exist.
//
// Ports
//   clk          rising-edge clock
//   rst_n        asynchronous active-low reset
//   shift_en     serial_in carries a valid bit this cycle
//   serial_in    serial data bit
//   frame_start  discard the partial word and restart the bit count
//   word_ready   consumer accepts word_data this cycle
//   overrun_clr  clears the sticky overrun flag
//   word_data    completed word (holding register)
//   word_valid   word_data holds an unconsumed word
//   overrun      sticky flag: a completed word was dropped
//   bit_count    bits received in the current partial word
//   parity_err   parity check result of the held word (parity build only)
// ---------------------------------------------------------------------------
module serial_word_capture #(
    parameter int WIDTH     = 8,
    parameter bit MSB_FIRST = 1'b1
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       shift_en,
    input  logic                       serial_in,
    input  logic                       frame_start,
    input  logic                       word_ready,
    input  logic                       overrun_clr,
    output logic [WIDTH-1:0]           word_data,
    output logic                       word_valid,
    output logic                       overrun,
    output logic [$clog2(WIDTH+1)-1:0] bit_count
`ifdef CAPTURE_PARITY_EN
    ,
    output logic                       parity_err
`endif
);

    localparam int CW = $clog2(WIDTH+1);

`ifdef CAPTURE_PARITY_EN
    localparam int FRAME_LEN = WIDTH + 1;
`else
    localparam int FRAME_LEN = WIDTH;
`endif

    localparam logic [CW-1:0] LAST_IDX = CW'(FRAME_LEN - 1);

    logic [WIDTH-1:0] shreg;
    logic [WIDTH-1:0] shreg_base;
    logic [WIDTH-1:0] shifted;
    logic [WIDTH-1:0] shreg_nxt;
    logic [WIDTH-1:0] word_new;
    logic [CW-1:0]    count_base;
    logic [CW-1:0]    count_nxt;
    logic             last_bit;
    logic             accept;
    logic             drop;

`ifdef CAPTURE_PARITY_EN
    logic par_acc;
    logic par_base;
    logic par_nxt;
    logic parity_new;
`endif

    // frame_start restarts the frame before this cycle's bit is applied.
    // As a result, a bit that arrives together with frame_start becomes
    // bit 0 of the new word.
    always_comb begin
        count_base = frame_start ? '0 : bit_count;
        shreg_base = frame_start ? '0 : shreg;
        last_bit   = shift_en && (count_base == LAST_IDX);

        if (MSB_FIRST) begin
            shifted = {shreg_base[WIDTH-2:0], serial_in};
        end else begin
            shifted = {serial_in, shreg_base[WIDTH-1:1]};
        end

`ifdef CAPTURE_PARITY_EN
        // The parity bit is not stored in the word. It only closes the
        // running XOR of the data bits.
        par_base   = frame_start ? 1'b0 : par_acc;
        word_new   = shreg_base;
        parity_new = par_base ^ serial_in;
        par_nxt    = par_base;
        if (shift_en) begin
            par_nxt = last_bit ? 1'b0 : (par_base ^ serial_in);
        end
`else
        word_new   = shifted;
`endif

        shreg_nxt = shreg_base;
        count_nxt = count_base;
        if (shift_en) begin
            if (last_bit) begin
                shreg_nxt = '0;
                count_nxt = '0;
            end else begin
                shreg_nxt = shifted;
                count_nxt = count_base + CW'(1);
            end
        end

        // A completed word is accepted if the holding slot is empty or
        // is being emptied on this same edge. Otherwise the word is dropped.
        accept = last_bit && (!word_valid || word_ready);
        drop   = last_bit && word_valid && !word_ready;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shreg     <= '0;
            bit_count <= '0;
        end else begin
            shreg     <= shreg_nxt;
            bit_count <= count_nxt;
        end
    end

`ifdef CAPTURE_PARITY_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            par_acc    <= 1'b0;
            parity_err <= 1'b0;
        end else begin
            par_acc <= par_nxt;
            if (accept) begin
                parity_err <= parity_new;
            end
        end
    end
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            word_data  <= '0;
            word_valid <= 1'b0;
        end else if (accept) begin
            word_data  <= word_new;
            word_valid <= 1'b1;
        end else if (word_valid && word_ready) begin
            word_valid <= 1'b0;
        end
    end

    // When a drop and overrun_clr occur on the same edge, the set wins.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            overrun <= 1'b0;
        end else if (drop) begin
            overrun <= 1'b1;
        end else if (overrun_clr) begin
            overrun <= 1'b0;
        end
    end

endmodule

// File: tb/tb_serial_word_capture.sv
// ---------------------------------------------------------------------------
// tb_serial_word_capture
//
// Directed-vector bench for serial_word_capture with WIDTH = 8 and
// MSB_FIRST = 1. Expected values are computed by hand from the stimulus.
// When CAPTURE_PARITY_EN is defined, every frame carries a trailing
// even-parity bit, and parity_err is checked as well.
// ---------------------------------------------------------------------------
module tb_serial_word_capture;

    logic       clk;
    logic       rst_n;
    logic       shift_en;
    logic       serial_in;
    logic       frame_start;
    logic       word_ready;
    logic       overrun_clr;
    logic [7:0] word_data;
    logic       word_valid;
    logic       overrun;
    logic [3:0] bit_count;
`ifdef CAPTURE_PARITY_EN
    logic       parity_err;
`endif

    int n_vec;
    int n_err;

    serial_word_capture #(.WIDTH(8), .MSB_FIRST(1'b1)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .shift_en    (shift_en),
        .serial_in   (serial_in),
        .frame_start (frame_start),
        .word_ready  (word_ready),
        .overrun_clr (overrun_clr),
        .word_data   (word_data),
        .word_valid  (word_valid),
        .overrun     (overrun),
        .bit_count   (bit_count)
`ifdef CAPTURE_PARITY_EN
        ,
        .parity_err  (parity_err)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Waits for the next rising edge, then samples 1 time unit after it.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic shift_bit(input logic b);
        shift_en  = 1'b1;
        serial_in = b;
        step();
        shift_en  = 1'b0;
    endtask

    // Shifts one full frame, MSB first. In the parity build, an even-parity
    // bit is appended. word_ready and overrun_clr can be asserted on the
    // final bit only.
    task automatic shift_frame(input logic [7:0] w, input logic rdy_last, input logic clr_last);
        logic [8:0] bits;
        int         n;
`ifdef CAPTURE_PARITY_EN
        bits = {w, ^w};
        n    = 9;
`else
        bits = {1'b0, w};
        n    = 8;
`endif
        for (int i = n - 1; i >= 0; i--) begin
            if (i == 0) begin
                word_ready  = rdy_last;
                overrun_clr = clr_last;
            end
            shift_bit(bits[i]);
        end
        word_ready  = 1'b0;
        overrun_clr = 1'b0;
    endtask

    task automatic pulse_ready();
        word_ready = 1'b1;
        step();
        word_ready = 1'b0;
    endtask

    initial begin
        n_vec       = 0;
        n_err       = 0;
        rst_n       = 1'b1;
        shift_en    = 1'b0;
        serial_in   = 1'b0;
        frame_start = 1'b0;
        word_ready  = 1'b0;
        overrun_clr = 1'b0;

        #3 rst_n = 1'b0;
        #1;
        chk("rst_data",  word_data,  32'h0);
        chk("rst_valid", word_valid, 32'h0);
        chk("rst_ovr",   overrun,    32'h0);
        chk("rst_cnt",   bit_count,  32'h0);
`ifdef CAPTURE_PARITY_EN
        chk("rst_perr",  parity_err, 32'h0);
`endif
        #18 rst_n = 1'b1;

        // Partial word: 7 bits of 0xA5 (1,0,1,0,0,1,0).
        shift_bit(1); shift_bit(0); shift_bit(1); shift_bit(0);
        shift_bit(0); shift_bit(1); shift_bit(0);
        chk("part_cnt",   bit_count,  32'd7);
        chk("part_valid", word_valid, 32'h0);
`ifdef CAPTURE_PARITY_EN
        shift_bit(1);
        shift_bit(0);
`else
        shift_bit(1);
`endif
        chk("a5_data",  word_data,  32'hA5);
        chk("a5_valid", word_valid, 32'h1);
        chk("a5_cnt",   bit_count,  32'h0);
        chk("a5_ovr",   overrun,    32'h0);
`ifdef CAPTURE_PARITY_EN
        chk("a5_perr",  parity_err, 32'h0);
`endif

        // Consume the held word, then deliver the next one.
        pulse_ready();
        chk("take_valid", word_valid, 32'h0);
        chk("take_data",  word_data,  32'hA5);
        pulse_ready();
        chk("idle_ready_valid", word_valid, 32'h0);
        shift_frame(8'h3C, 1'b0, 1'b0);
        chk("3c_data",  word_data,  32'h3C);
        chk("3c_valid", word_valid, 32'h1);

        // Overrun: 0xA5 is accepted, and 0xFF is dropped.
        pulse_ready();
        shift_frame(8'hA5, 1'b0, 1'b0);
        shift_frame(8'hFF, 1'b0, 1'b0);
        chk("ovr_data",  word_data,  32'hA5);
        chk("ovr_flag",  overrun,    32'h1);
        chk("ovr_valid", word_valid, 32'h1);
        overrun_clr = 1'b1;
        step();
        overrun_clr = 1'b0;
        chk("ovr_clr", overrun, 32'h0);

        // A drop and overrun_clr on the same edge: the set wins.
        shift_frame(8'h55, 1'b0, 1'b1);
        chk("ovr_setwins", overrun,   32'h1);
        chk("ovr_sw_data", word_data, 32'hA5);
        overrun_clr = 1'b1;
        step();
        overrun_clr = 1'b0;
        chk("ovr_clr2", overrun, 32'h0);

        // word_ready is asserted on the completing edge while 0xA5 is held.
        shift_frame(8'h0F, 1'b1, 1'b0);
        chk("sim_data",  word_data,  32'h0F);
        chk("sim_valid", word_valid, 32'h1);
        chk("sim_ovr",   overrun,    32'h0);

        // frame_start without shift_en only clears the count.
        shift_bit(1); shift_bit(1);
        frame_start = 1'b1;
        step();
        frame_start = 1'b0;
        chk("fs_idle_cnt",   bit_count,  32'h0);
        chk("fs_idle_valid", word_valid, 32'h1);
        chk("fs_idle_data",  word_data,  32'h0F);

        // frame_start together with a bit restarts the frame at that bit.
        pulse_ready();
        shift_bit(1); shift_bit(1); shift_bit(1);
        chk("fs_pre_cnt", bit_count, 32'd3);
        frame_start = 1'b1;
        shift_bit(1);
        frame_start = 1'b0;
        chk("fs_cnt",   bit_count,  32'd1);
        chk("fs_valid", word_valid, 32'h0);
        for (int i = 0; i < 7; i++) shift_bit(0);
`ifdef CAPTURE_PARITY_EN
        shift_bit(1);
`endif
        chk("fs_data",  word_data,  32'h80);
        chk("fs_valid2", word_valid, 32'h1);

        // Asynchronous reset in the middle of a word, between clock edges.
        shift_bit(1); shift_bit(0); shift_bit(1);
        overrun_clr = 1'b0;
        #3 rst_n = 1'b0;
        #1;
        chk("arst_data",  word_data,  32'h0);
        chk("arst_valid", word_valid, 32'h0);
        chk("arst_cnt",   bit_count,  32'h0);
        chk("arst_ovr",   overrun,    32'h0);
        #2 rst_n = 1'b1;
        #1;

        // A complete word after reset shows that the partial word was lost.
        shift_frame(8'hC3, 1'b0, 1'b0);
        chk("post_rst_data", word_data, 32'hC3);
        pulse_ready();

`ifdef CAPTURE_PARITY_EN
        // 0xA5 has four ones, so parity bit 1 is a parity error.
        for (int i = 7; i >= 0; i--) begin
            logic [7:0] w;
            w = 8'hA5;
            shift_bit(w[i]);
        end
        shift_bit(1);
        chk("par_bad_data", word_data,  32'hA5);
        chk("par_bad",      parity_err, 32'h1);
        pulse_ready();
        for (int i = 7; i >= 0; i--) begin
            logic [7:0] w;
            w = 8'hA5;
            shift_bit(w[i]);
        end
        shift_bit(0);
        chk("par_good", parity_err, 32'h0);
        chk("par_good_valid", word_valid, 32'h1);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
